// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (non-restoring) unit.
// Optional MULTDIV_EARLY_OUT_EN: trivial operands (either operand zero) finish in one edge.
`default_nettype none

module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             trivial;
  // Booth: {acc, mplier, q_prev}; acc carries one guard bit so the most negative
  // multiplicand cannot overflow the partial sum before the arithmetic shift.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mplier;
  logic             q_prev;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH+1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dmag;
  logic             quo_neg;
  logic             div_zero;
  logic             div_ovf;

  logic             start;
  logic             trivial_start;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mcand_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] rem_next;
  logic [WIDTH:0]   prod_hi;
  logic [WIDTH-1:0] fin_result;
  logic             fin_exc;

  assign start = ctrl_MULT | ctrl_DIV;
  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

`ifdef MULTDIV_EARLY_OUT_EN
  assign trivial_start = (data_operandA == '0) || (data_operandB == '0);
`else
  assign trivial_start = 1'b0;
`endif

  assign mcand_ext = {mcand[WIDTH-1], mcand};
  always_comb begin
    booth_sum = acc;
    case ({mplier[0], q_prev})
      2'b01:   booth_sum = acc + mcand_ext;
      2'b10:   booth_sum = acc - mcand_ext;
      default: booth_sum = acc;
    endcase
  end

  assign shifted  = {rem[WIDTH:0], quo[WIDTH-1]};
  assign rem_next = rem[WIDTH+1] ? shifted + {2'b00, dmag} : shifted - {2'b00, dmag};

  assign prod_hi = {acc[WIDTH-1:0], mplier[WIDTH-1]};

  always_comb begin
    fin_result = '0;
    fin_exc    = 1'b0;
    if (trivial) begin
      fin_exc = (state == DIV) && div_zero;
    end else if (state == MUL) begin
      fin_result = mplier;
      fin_exc    = !((&prod_hi) || !(|prod_hi));
    end else if (div_zero || div_ovf) begin
      fin_exc = 1'b1;
    end else begin
      fin_result = quo_neg ? -quo : quo;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      trivial        <= 1'b0;
      acc            <= '0;
      mplier         <= '0;
      q_prev         <= 1'b0;
      mcand          <= '0;
      rem            <= '0;
      quo            <= '0;
      dmag           <= '0;
      quo_neg        <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        // A start pulse always wins, aborting whatever is in flight.
        state          <= ctrl_MULT ? MUL : DIV;
        count          <= '0;
        trivial        <= trivial_start;
        acc            <= '0;
        mplier         <= data_operandB;
        q_prev         <= 1'b0;
        mcand          <= data_operandA;
        rem            <= '0;
        quo            <= a_mag;
        dmag           <= b_mag;
        quo_neg        <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero       <= (data_operandB == '0);
        div_ovf        <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
        data_result    <= '0;
        data_exception <= 1'b0;
        busy           <= 1'b1;
      end else begin
        case (state)
          MUL, DIV: begin
            if (trivial || count == LAST) begin
              state          <= DONE;
              data_result    <= fin_result;
              data_exception <= fin_exc;
              data_resultRDY <= 1'b1;
              busy           <= 1'b0;
            end else begin
              count <= count + CW'(1);
              if (state == MUL) begin
                acc    <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                mplier <= {booth_sum[0], mplier[WIDTH-1:1]};
                q_prev <= mplier[0];
              end else begin
                rem <= rem_next;
                quo <= {quo[WIDTH-2:0], ~rem_next[WIDTH+1]};
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multdiv_unit.sv
// Randomized self-checking bench for multdiv_unit against an arithmetic reference model.
`default_nettype none

module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: {exception, result} from plain signed arithmetic.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic is_mul);
    longint p;
    longint q;
    if (is_mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return {(p != longint'($signed(p[31:0]))), p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'd0};
    q = longint'($signed(a)) / longint'($signed(b));
    return {1'b0, q[31:0]};
  endfunction

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef MULTDIV_EARLY_OUT_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0:       v = 32'($urandom_range(0, 200)) - 32'd100;
      1:       v = 32'd0;
      2:       v = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(0, 65535));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Called at a negedge; leaves us at the negedge right after the last start edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic m, input logic d,
                          input int hold);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    repeat (hold) @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic finish_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic is_mul);
    int          lat;
    logic [32:0] exp;
    logic [31:0] res;
    exp = model(a, b, is_mul);
    wait_done(lat);
    check({tag, "_latency"}, 64'(lat), 64'(exp_latency(a, b)));
    check({tag, "_result"}, 64'(data_result), 64'(exp[31:0]));
    check({tag, "_exception"}, 64'(data_exception), 64'(exp[32]));
    check({tag, "_busy_at_rdy"}, 64'(busy), 64'd0);
    res = data_result;
    @(negedge clock);
    check({tag, "_rdy_pulse"}, 64'(data_resultRDY), 64'd0);
    check({tag, "_held"}, 64'(data_result), 64'(res));
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic m, input logic d);
    start_op(a, b, m, d, 1);
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    finish_op(tag, a, b, m);
  endtask

  initial begin
    int          rdy_count;
    logic [31:0] a;
    logic [31:0] b;
    logic        m;

    repeat (3) @(negedge clock);
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exc", 64'(data_exception), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    do_op("mul_7x-6", 32'd7, 32'hFFFF_FFFA, 1'b1, 1'b0);
    do_op("mul_ovf", 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
    do_op("div_-17/5", 32'hFFFF_FFEF, 32'd5, 1'b0, 1'b1);
    do_op("div_min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    do_op("div_by_0", 32'd123, 32'd0, 1'b0, 1'b1);
    do_op("mul_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    do_op("both_ctrl", 32'd3, 32'd4, 1'b1, 1'b1);

    // Abort a MULT by pulsing DIV at edge 5.
    start_op(32'd3, 32'd4, 1'b1, 1'b0, 1);
    rdy_count = 0;
    repeat (4) begin
      @(negedge clock);
      if (data_resultRDY) rdy_count++;
    end
    check("abort_no_early_rdy", 64'(rdy_count), 64'd0);
    start_op(32'd100, 32'd7, 1'b0, 1'b1, 1);
    finish_op("abort_div", 32'd100, 32'd7, 1'b0);

    // Held start level restarts each cycle; latency counts from the last high edge.
    start_op(32'hFFFF_FFF6, 32'd3, 1'b0, 1'b1, 3);
    finish_op("held_start", 32'hFFFF_FFF6, 32'd3, 1'b0);

    // Asynchronous reset in the middle of a multiply.
    start_op(32'd1234, 32'd5678, 1'b1, 1'b0, 1);
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_rdy", 64'(data_resultRDY), 64'd0);
    check("midreset_result", 64'(data_result), 64'd0);
    check("midreset_exc", 64'(data_exception), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    rdy_count = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) rdy_count++;
    end
    check("midreset_no_rdy", 64'(rdy_count), 64'd0);

    for (int i = 0; i < 40; i++) begin
      a = rand_operand();
      b = rand_operand();
      m = ($urandom_range(0, 1) == 1);
      do_op(m ? "rand_mul" : "rand_div", a, b, m, !m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
